// File: rtl/stack_write_ctrl_pkg.sv
// stack_write_ctrl_pkg: shared widths and push-source encodings for the hardware stack
package stack_write_ctrl_pkg;
  localparam int PC_W = 11;
  localparam int DATA8_W = 8;
  typedef enum logic {
    STACK_SRC_PC  = 1'b0,
    STACK_SRC_ACC = 1'b1
  } stack_src_e;
endpackage

// File: rtl/stack_ram.sv
// stack_ram: register array with one synchronous write port and one asynchronous read port
module stack_ram #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/stack_write_ctrl.sv
// stack_write_ctrl: push-source select, stack pointer, full/empty status and sticky error for the stack
import stack_write_ctrl_pkg::*;
module stack_write_ctrl #(
  parameter int DEPTH = 16,
  parameter int SP_W = 4,
  parameter int DATA_W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                StackSrc,
  input  logic [PC_W-1:0]     return_pc,
  input  logic [DATA8_W-1:0]  write_data_accbuf,
  output logic [DATA_W-1:0]   read_data_stack,
  output logic                rd_valid,
  output logic [SP_W:0]       sp,
  output logic                full,
  output logic                empty,
  output logic                stack_err
);
  localparam logic [SP_W:0] sp_max = (SP_W+1)'(DEPTH);
  logic [SP_W:0] sp_m1;
  logic [DATA_W-1:0] src_data, top_data;
  logic we, err, do_pop;
  assign full = sp == sp_max;
  assign empty = sp == '0;
  always_comb begin
    sp_m1 = sp - 1'b1;
    src_data = stack_src_e'(StackSrc) == STACK_SRC_ACC ? DATA_W'(write_data_accbuf) : DATA_W'(return_pc);
    do_pop = pop && !empty;
    // push+pop on a non-empty stack overwrites the top entry in place
    we = push && (pop ? !empty : !full);
    err = pop ? empty : push && full;
  end
  stack_ram #(.DEPTH(DEPTH), .AW(SP_W), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (pop ? sp_m1[SP_W-1:0] : sp[SP_W-1:0]),
    .wdata (src_data),
    .raddr (sp_m1[SP_W-1:0]),
    .rdata (top_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      read_data_stack <= '0;
      rd_valid <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) read_data_stack <= top_data;
      if (do_pop && !push) sp <= sp_m1;
      else if (push && !pop && !full) sp <= sp + 1'b1;
      if (err) stack_err <= 1'b1;
    end
  end
endmodule
